stream_sched: RTL and testbench

Shared-memory input-stream scheduler for the core complex. It fetches values for up to four input lanes from one single-ported stream memory. It arbitrates that memory's read port round-robin among the lanes and presents each lane to the core complex's upward ports with the `write`/`read` handshake used by the stream rows. It sits between the stream-data memory and `corecomplex` (`rreadyU`/`readU`/`up`) and replaces per-lane private stream storage.

---
 rtl/stream_sched_if.sv | 30 +++
 rtl/stream_sched.sv | 183 ++++++++++++++++++
 tb/tb_stream_sched.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_sched_if.sv
// Handshake and memory bundle between stream_sched and its environment.
// The master side is the scheduler. The slave side is the memory plus core harness.
interface stream_sched_if #(
    parameter int NL = 4,
    parameter int DW = 11,
    parameter int AW = 9,
    parameter int LW = 6
);
    logic                   start;
    logic [NL-1:0][LW-1:0]  length;
    logic [NL-1:0][AW-1:0]  base;
    logic                   mem_rd;
    logic [AW-1:0]          mem_addr;
    logic [DW-1:0]          mem_data;
    logic [NL-1:0]          write;
    logic [NL-1:0][DW-1:0]  out;
    logic [NL-1:0]          read;
    logic                   busy;
    logic                   done;

    modport master (
        input  start, length, base, mem_data, read,
        output mem_rd, mem_addr, write, out, busy, done
    );

    modport slave (
        output start, length, base, mem_data, read,
        input  mem_rd, mem_addr, write, out, busy, done
    );
endinterface

// File: rtl/stream_sched.sv
// Round-robin scheduler that shares one single-ported stream memory across NL lanes.
// Each lane fetches its next word only after the consumer has drained the previous word.

module stream_lane #(
    parameter int DW = 11,
    parameter int AW = 9,
    parameter int LW = 6
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          run_i,
    input  logic          grant_i,
    input  logic          read_i,
    input  logic [LW-1:0] length_i,
    input  logic [AW-1:0] base_i,
    input  logic [DW-1:0] mem_data_i,
    output logic          elig_o,
    output logic [AW-1:0] addr_o,
    output logic          write_o,
    output logic [DW-1:0] out_o,
    output logic          fin_o
);
    logic [LW-1:0] rem_q, rem_d;
    logic [LW-1:0] idx_q, idx_d;
    logic [AW-1:0] base_q, base_d;
    logic          pend_q, pend_d;
    logic          write_q, write_d;
    logic [DW-1:0] out_q, out_d;

    always_comb begin
        rem_d   = rem_q;
        idx_d   = idx_q;
        base_d  = base_q;
        pend_d  = pend_q;
        write_d = write_q;
        out_d   = out_q;
        if (start_i) begin
            rem_d   = length_i;
            idx_d   = '0;
            base_d  = base_i;
            pend_d  = 1'b0;
            write_d = 1'b0;
        end else begin
            // A capture keeps write high even if the old word is taken on the same edge.
            if (pend_q) begin
                out_d   = mem_data_i;
                write_d = 1'b1;
                pend_d  = 1'b0;
            end else if (write_q && read_i) begin
                write_d = 1'b0;
            end
            if (grant_i) begin
                pend_d = 1'b1;
                idx_d  = idx_q + LW'(1);
                rem_d  = rem_q - LW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rem_q   <= '0;
            idx_q   <= '0;
            base_q  <= '0;
            pend_q  <= 1'b0;
            write_q <= 1'b0;
            out_q   <= '0;
        end else begin
            rem_q   <= rem_d;
            idx_q   <= idx_d;
            base_q  <= base_d;
            pend_q  <= pend_d;
            write_q <= write_d;
            out_q   <= out_d;
        end
    end

    assign elig_o  = run_i && (rem_q != '0) && !pend_q && (!write_q || read_i);
    assign addr_o  = base_q + AW'(idx_q);
    assign write_o = write_q;
    assign out_o   = out_q;
    assign fin_o   = (rem_q == '0) && !pend_q && !write_q;
endmodule

module stream_sched #(
    parameter int NL = 4,
    parameter int DW = 11,
    parameter int AW = 9,
    parameter int LW = 6
) (
    input  logic           clk_i,
    input  logic           rst_i,
    stream_sched_if.master bus
);
    localparam int PW = (NL > 1) ? $clog2(NL) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         ptr_q, ptr_d;
    logic                  run, start_run, all_fin;
    logic [NL-1:0]         elig, fin, gnt_vec, write_w;
    logic [NL-1:0][AW-1:0] lane_addr;
    logic [NL-1:0][DW-1:0] out_w;
    logic                  gnt_vld;
    logic [PW-1:0]         gnt_idx, cand;

    assign run       = (state_q == RUN);
    assign start_run = bus.start && (state_q != RUN);
    assign all_fin   = &fin;

    for (genvar l = 0; l < NL; l++) begin : g_lane
        stream_lane #(.DW(DW), .AW(AW), .LW(LW)) u_lane (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .start_i    (start_run),
            .run_i      (run),
            .grant_i    (gnt_vec[l]),
            .read_i     (bus.read[l]),
            .length_i   (bus.length[l]),
            .base_i     (bus.base[l]),
            .mem_data_i (bus.mem_data),
            .elig_o     (elig[l]),
            .addr_o     (lane_addr[l]),
            .write_o    (write_w[l]),
            .out_o      (out_w[l]),
            .fin_o      (fin[l])
        );
    end

    // Search upward from the pointer and wrap; the first eligible lane wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 0; k < NL; k++) begin
            cand = PW'((int'(ptr_q) + k) % NL);
            if (!gnt_vld && elig[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_comb begin
        gnt_vec = '0;
        if (gnt_vld) gnt_vec[gnt_idx] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE, DONE: if (bus.start) state_d = RUN;
            RUN:        if (all_fin)   state_d = DONE;
            default:    state_d = IDLE;
        endcase
        if (start_run)    ptr_d = '0;
        else if (gnt_vld) ptr_d = PW'((int'(gnt_idx) + 1) % NL);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.mem_rd   = gnt_vld;
    assign bus.mem_addr = gnt_vld ? lane_addr[gnt_idx] : '0;
    assign bus.write    = write_w;
    assign bus.out      = out_w;
    assign bus.busy     = (state_q == RUN);
    assign bus.done     = (state_q == DONE);
endmodule

// File: tb/tb_stream_sched.sv
// Directed bench for stream_sched with a one-cycle-latency memory model.
module tb_stream_sched;
    localparam int NL = 4;
    localparam int DW = 11;
    localparam int AW = 9;
    localparam int LW = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stream_sched_if #(.NL(NL), .DW(DW), .AW(AW), .LW(LW)) bus();

    stream_sched #(.NL(NL), .DW(DW), .AW(AW), .LW(LW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.master)
    );

    logic [DW-1:0] mem [0:(1<<AW)-1];
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (bus.mem_rd) bus.mem_data <= mem[bus.mem_addr];

    logic [AW-1:0] g_addr[$];
    int            g_cyc[$];
    int            t_lane[$];
    logic [DW-1:0] t_val[$];
    int            t_cyc[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mem_rd) begin
                g_addr.push_back(bus.mem_addr);
                g_cyc.push_back(cyc);
            end
            for (int l = 0; l < NL; l++) begin
                if (bus.write[l] && bus.read[l]) begin
                    t_lane.push_back(l);
                    t_val.push_back(bus.out[l]);
                    t_cyc.push_back(cyc);
                end
            end
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input int a);
        return DW'(a * 3 + 7);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        g_addr.delete(); g_cyc.delete();
        t_lane.delete(); t_val.delete(); t_cyc.delete();
    endtask

    task automatic go(output int k);
        bus.start = 1'b1;
        step();
        k = cyc;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int dc);
        dc = -1;
        for (int i = 0; i < budget && dc < 0; i++) begin
            step();
            if (bus.done) dc = cyc;
        end
        chk("done_reached", 32'(dc >= 0), 1);
    endtask

    int k, k2, dc, a, cnt;
    int ea[8];
    int bases[4];

    initial begin
        bus.start = 1'b0; bus.length = '0; bus.base = '0; bus.read = '0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = pat(i);
        mem[10] = 11'd5; mem[11] = 11'h7F9; mem[12] = 11'h3FF;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",  32'(bus.busy), 0);
        chk("rst_done",  32'(bus.done), 0);
        chk("rst_write", 32'(bus.write), 0);
        chk("rst_memrd", 32'(bus.mem_rd), 0);
        chk("rst_addr",  32'(bus.mem_addr), 0);
        chk("rst_out",   32'(bus.out != '0), 0);
        rst = 1'b0;
        step();

        // single lane, read tied high
        bus.length[0] = 6'd3; bus.base[0] = 9'd10; bus.read = 4'b0001;
        clear_log();
        go(k);
        chk("t1_busy",  32'(bus.busy), 1);
        chk("t1_write", 32'(bus.write), 0);
        wait_done(40, dc);
        chk("t1_ntr", t_val.size(), 3);
        if (t_val.size() >= 3) begin
            chk("t1_v0", 32'(t_val[0]), 32'd5);
            chk("t1_v1", 32'(t_val[1]), 32'h7F9);
            chk("t1_v2", 32'(t_val[2]), 32'h3FF);
            for (int i = 0; i < 3; i++) chk($sformatf("t1_cyc%0d", i), t_cyc[i] - k, 2 + 2 * i);
        end
        chk("t1_done_cyc", dc - k, 8);

        // round robin over all lanes
        bases = '{0, 20, 40, 60};
        ea = '{0, 20, 40, 60, 1, 21, 41, 61};
        for (int l = 0; l < NL; l++) begin
            bus.length[l] = 6'd2;
            bus.base[l] = AW'(bases[l]);
        end
        bus.read = 4'hF;
        clear_log();
        go(k);
        wait_done(60, dc);
        chk("t2_ngrant", g_addr.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < g_addr.size()) begin
                chk($sformatf("t2_addr%0d", i), 32'(g_addr[i]), ea[i]);
                chk($sformatf("t2_gcyc%0d", i), g_cyc[i] - k, i);
            end
        end
        for (int l = 0; l < NL; l++) begin
            cnt = 0;
            for (int i = 0; i < t_val.size(); i++) begin
                if (t_lane[i] == l) begin
                    chk($sformatf("t2_l%0d_w%0d", l, cnt), 32'(t_val[i]), 32'(pat(bases[l] + cnt)));
                    cnt++;
                end
            end
            chk($sformatf("t2_l%0d_cnt", l), cnt, 2);
        end
        chk("t2_done_cyc", dc - k, 11);

        // back-pressure on lane 1
        bus.length = '0; bus.base = '0;
        bus.length[1] = 6'd2; bus.base[1] = 9'd100; bus.read = 4'b0000;
        clear_log();
        go(k);
        for (int i = 0; i < 10 && !bus.write[1]; i++) step();
        chk("t3_rise", cyc - k, 2);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t3_hold_out%0d", i), 32'(bus.out[1]), 32'(pat(100)));
            chk($sformatf("t3_hold_rd%0d", i), 32'(bus.mem_rd), 0);
            step();
        end
        a = cyc;
        bus.read[1] = 1'b1;
        #1;
        chk("t3_rd",   32'(bus.mem_rd), 1);
        chk("t3_addr", 32'(bus.mem_addr), 101);
        step();
        chk("t3_gap", 32'(bus.write[1]), 0);
        step();
        chk("t3_w2",  32'(bus.write[1]), 1);
        chk("t3_v2",  32'(bus.out[1]), 32'(pat(101)));
        chk("t3_lat", cyc - a, 2);
        wait_done(20, dc);
        chk("t3_ntr", t_val.size(), 2);
        chk("t3_ngr", g_addr.size(), 2);
        if (g_cyc.size() >= 2) chk("t3_gcyc", g_cyc[1], a);

        // zero lengths, then restart
        bus.length = '0; bus.read = 4'hF;
        clear_log();
        go(k);
        chk("t4_busy", 32'(bus.busy), 1);
        chk("t4_done0", 32'(bus.done), 0);
        step();
        chk("t4_done1", 32'(bus.done), 1);
        chk("t4_idle", 32'(bus.busy), 0);
        bus.length[2] = 6'd1; bus.base[2] = 9'd200;
        clear_log();
        go(k2);
        chk("t4_restart_done", 32'(bus.done), 0);
        chk("t4_restart_busy", 32'(bus.busy), 1);
        wait_done(20, dc);
        chk("t4_ntr", t_val.size(), 1);
        if (t_val.size() >= 1) begin
            chk("t4_lane", t_lane[0], 2);
            chk("t4_val", 32'(t_val[0]), 32'(pat(200)));
        end

        // address wrap and ignored mid-run start
        bus.length = '0; bus.base = '0;
        bus.length[3] = 6'd2; bus.base[3] = 9'd511;
        clear_log();
        go(k);
        step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("t5_busy", 32'(bus.busy), 1);
        wait_done(20, dc);
        chk("t5_ngr", g_addr.size(), 2);
        if (g_addr.size() >= 2) begin
            chk("t5_a0", 32'(g_addr[0]), 511);
            chk("t5_a1", 32'(g_addr[1]), 0);
        end
        chk("t5_ntr", t_val.size(), 2);
        if (t_val.size() >= 2) begin
            chk("t5_v0", 32'(t_val[0]), 32'(pat(511)));
            chk("t5_v1", 32'(t_val[1]), 32'(pat(0)));
        end
        chk("t5_done_cyc", dc - k, 6);

        // reset one cycle after a grant
        bus.length = '0; bus.base = '0;
        bus.length[0] = 6'd3; bus.base[0] = 9'd300;
        clear_log();
        go(k);
        step();
        rst = 1'b1;
        #1;
        chk("t6_write", 32'(bus.write), 0);
        chk("t6_busy",  32'(bus.busy), 0);
        chk("t6_memrd", 32'(bus.mem_rd), 0);
        chk("t6_done",  32'(bus.done), 0);
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("t6_nocap_w%0d", i), 32'(bus.write), 0);
            chk($sformatf("t6_nocap_o%0d", i), 32'(bus.out != '0), 0);
        end
        bus.length[0] = 6'd1; bus.base[0] = 9'd5;
        clear_log();
        go(k);
        chk("t6_new_rd",   32'(bus.mem_rd), 1);
        chk("t6_new_addr", 32'(bus.mem_addr), 5);
        wait_done(20, dc);
        chk("t6_ntr", t_val.size(), 1);
        if (t_val.size() >= 1) begin
            chk("t6_lane", t_lane[0], 0);
            chk("t6_val", 32'(t_val[0]), 32'(pat(5)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
